transport_send_arbiter: RTL
===========================

Name: transport_send_arbiter

Overview:
Transmit-side scheduler for the transport layer. Shares the single byte-wide network send path between two session-layer requesters: 16-bit control commands and a 16-bit audio sample stream. It buffers audio samples and frames each transfer as a fixed-length packet: a header byte (0x40 control, 0x80 audio), a payload sent MSB byte first, and zero padding. Packets are emitted one byte per strobe in the same format the receive side parses.

Parameters:
AUDIO_SAMPLES, 8, audio samples per packet; packet length PKT_BYTES = 1 + 2*AUDIO_SAMPLES (17 by default)
AUDIO_DEPTH, 16, audio sample buffer depth in samples; must be >= AUDIO_SAMPLES and a power of two

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
ctrlReq  in  1  control command pending; held until ctrlAck
ctrlCmd  in  16  control command word; stable while ctrlReq is high
ctrlAck  out  1  one-cycle pulse: command latched, packet scheduled
audioValid  in  1  one-cycle write strobe for audioSample
audioSample  in  16  audio sample
audioOverflow  out  1  sticky: a sample was dropped because the buffer was full
netBusy  in  1  network cannot accept a byte this cycle
sendSignal  out  1  one-cycle strobe: packetOut valid
packetOut  out  8  packet byte
txActive  out  1  high from packet selection until last byte sent

Behaviour:
- Reset (synchronous, dominant over every other input):
  - ctrlAck, sendSignal, txActive, audioOverflow = 0; packetOut = 0x00.
  - Audio buffer emptied; FSM to IDLE; byte counter = 0; lastWasCtrl = 0.
  - Reset mid-packet aborts the packet. No remaining bytes are sent, and sendSignal is 0 in the cycle after reset is sampled.
- All outputs are registered.
- Audio buffer:
  - Circular array with write pointer, read pointer and count (0..AUDIO_DEPTH).
  - audioValid with count == AUDIO_DEPTH: sample dropped, audioOverflow set (cleared only by reset).
  - A write and a pop in the same cycle leave count unchanged. The write succeeds even when count == AUDIO_DEPTH at that edge.
  - Pointers wrap modulo AUDIO_DEPTH.
  - audioReady = (count >= AUDIO_SAMPLES).
- FSM states: IDLE, SEND_CTRL, SEND_AUDIO.
- IDLE arbitration:
  - ctrlReq only: go to SEND_CTRL.
  - audioReady only: go to SEND_AUDIO.
  - Both: SEND_AUDIO if lastWasCtrl = 1, else SEND_CTRL (strict alternation on ties, control wins the first tie after reset).
  - Neither: stay in IDLE.
- Entering SEND_CTRL: latch ctrlCmd, pulse ctrlAck for exactly one cycle (the cycle after ctrlReq is sampled), set lastWasCtrl = 1.
- Entering SEND_AUDIO: set lastWasCtrl = 0.
- txActive = 1 in SEND_CTRL/SEND_AUDIO.
- Byte emission:
  - In SEND_*, at each edge with netBusy = 0: sendSignal = 1, packetOut = byte[idx], idx increments.
  - With netBusy = 1: sendSignal = 0, idx holds, packetOut holds.
  - First byte (header) appears no earlier than the cycle after ctrlAck / after state entry.
- Control packet: byte0 = 0x40, byte1 = cmd[15:8], byte2 = cmd[7:0], bytes 3..PKT_BYTES-1 = 0x00.
- Audio packet:
  - byte0 = 0x80, then for each of AUDIO_SAMPLES samples in FIFO order: sample[15:8], then sample[7:0].
  - The sample is popped on the edge its low byte is sent.
- After the byte with idx = PKT_BYTES-1 is sent: return to IDLE, txActive = 0 the following cycle.
  - Arbitration can start the next packet from that IDLE cycle, so back-to-back packets have exactly one idle cycle between them (sendSignal gap ≥ 2 cycles).
- ctrlReq arriving mid-packet waits. Audio samples keep being accepted during any packet.

Test Plan:
- Reset, ctrlReq with ctrlCmd = 0xABCD, netBusy = 0 -> ctrlAck pulses once; 17 consecutive strobes 40 AB CD then 14×00; txActive falls after the last byte.
- Write samples 0x0001..0x0008, no ctrlReq -> strobes 80 00 01 00 02 … 00 08; buffer count returns to 0; ctrlAck never pulses.
- Audio packet with netBusy high for 3 cycles after byte 5 -> no strobe during the stall; byte sequence unchanged and complete; total packet span is 20 cycles.
- ctrlReq held and 16 samples buffered simultaneously at IDLE -> order is control, audio, then a second control request on the next tie wins over the remaining 8 samples (alternation).
- netBusy held high, 17 audioValid strobes -> audioOverflow = 1 after the 17th; after netBusy drops, exactly 16 samples (0x0001..0x0010) are emitted over two packets.
- Assert reset during byte 6 of an audio packet -> sendSignal = 0 the next cycle; no further bytes; count = 0; audioOverflow = 0; a following ctrlReq produces a clean 0x40 packet.

Source files
------------

// File: rtl/transport_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : transport_send_arbiter
// Description : Frames control commands and buffered audio samples into
//               fixed-length packets on a shared byte-wide send path.
// Revision    : 1.0 - initial release
// ============================================================================
module transport_send_arbiter #(
  parameter int AUDIO_SAMPLES = 8,
  parameter int AUDIO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrlReq,
  input  logic [15:0] ctrlCmd,
  output logic        ctrlAck,
  input  logic        audioValid,
  input  logic [15:0] audioSample,
  output logic        audioOverflow,
  input  logic        netBusy,
  output logic        sendSignal,
  output logic [7:0]  packetOut,
  output logic        txActive
);

  localparam int PKT_BYTES = 1 + 2 * AUDIO_SAMPLES;
  localparam int c_IDX_W   = $clog2(PKT_BYTES);
  localparam int c_PTR_W   = $clog2(AUDIO_DEPTH);
  localparam int c_CNT_W   = $clog2(AUDIO_DEPTH + 1);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PKT_BYTES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_0    = c_IDX_W'(0);
  localparam logic [c_IDX_W-1:0] c_IDX_1    = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_2    = c_IDX_W'(2);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(AUDIO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_READY    = c_CNT_W'(AUDIO_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND_CTRL  = 2'd1,
    ST_SEND_AUDIO = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 last_ctrl_q, last_ctrl_d;
  logic                 ack_q, ack_d;
  logic                 send_q, send_d;
  logic [7:0]           pkt_q, pkt_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;

  logic [15:0]          mem_q [AUDIO_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]   count_q, count_d;

  logic                 w_full;
  logic                 w_audio_ready;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [15:0]          w_head;
  logic [7:0]           w_byte;

  // ---------------------------------------------------------------------------
  // Audio sample buffer
  // ---------------------------------------------------------------------------
  assign w_full        = (count_q == c_FULL);
  assign w_audio_ready = (count_q >= c_READY);
  assign w_head        = mem_q[rd_ptr_q];
  // A same-cycle pop frees the slot the incoming sample needs.
  assign w_push        = audioValid && (!w_full || w_pop);
  assign w_drop        = audioValid && w_full && !w_pop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      mem_q[wr_ptr_q] <= audioSample;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet byte selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte = 8'h00;
    if (state_q == ST_SEND_CTRL) begin
      if (idx_q == c_IDX_0)      w_byte = 8'h40;
      else if (idx_q == c_IDX_1) w_byte = cmd_q[15:8];
      else if (idx_q == c_IDX_2) w_byte = cmd_q[7:0];
    end else if (state_q == ST_SEND_AUDIO) begin
      if (idx_q == c_IDX_0)      w_byte = 8'h80;
      else if (idx_q[0])         w_byte = w_head[15:8];
      else                       w_byte = w_head[7:0];
    end
  end

  // Samples leave the buffer as their low byte goes out (even, non-zero index).
  assign w_pop = (state_q == ST_SEND_AUDIO) && !netBusy &&
                 (idx_q != c_IDX_0) && !idx_q[0];

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    last_ctrl_d = last_ctrl_q;
    ack_d       = 1'b0;
    send_d      = 1'b0;
    pkt_d       = pkt_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = c_IDX_0;
        if (ctrlReq && (!w_audio_ready || !last_ctrl_q)) begin
          state_d     = ST_SEND_CTRL;
          cmd_d       = ctrlCmd;
          ack_d       = 1'b1;
          last_ctrl_d = 1'b1;
        end else if (w_audio_ready) begin
          state_d     = ST_SEND_AUDIO;
          last_ctrl_d = 1'b0;
        end
      end
      ST_SEND_CTRL, ST_SEND_AUDIO: begin
        if (!netBusy) begin
          send_d = 1'b1;
          pkt_d  = w_byte;
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = c_IDX_0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cmd_q       <= '0;
      last_ctrl_q <= 1'b0;
      ack_q       <= 1'b0;
      send_q      <= 1'b0;
      pkt_q       <= 8'h00;
      tx_q        <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      last_ctrl_q <= last_ctrl_d;
      ack_q       <= ack_d;
      send_q      <= send_d;
      pkt_q       <= pkt_d;
      tx_q        <= tx_d;
      ovf_q       <= ovf_q | w_drop;
      count_q     <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign ctrlAck       = ack_q;
  assign sendSignal    = send_q;
  assign packetOut     = pkt_q;
  assign txActive      = tx_q;
  assign audioOverflow = ovf_q;

endmodule
`default_nettype wire
